// File: rtl/xcvr_clkout_freq_monitor.sv
// Per-channel frequency monitor for transceiver clkout signals: synchronises each
// clkout into clk, counts its rising edges over a fixed gate window and flags dead clocks.
module xcvr_clkout_freq_monitor #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int GATE_CYCLES = 100000,
  parameter int CNT_W       = 20,
  parameter int MIN_EDGES   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       clkout_in,
  input  logic [NUM_CH-1:0]       lost_clr,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic                    count_valid,
  output logic [NUM_CH-1:0]       clk_active,
  output logic [NUM_CH-1:0]       lost_sticky
);

  localparam int               WIN_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   MIN_C    = (CNT_W + 1)'(MIN_EDGES);

  logic [WIN_W-1:0] r_win;
  logic             r_count_valid;
  logic             w_term;

  assign w_term = enable & (r_win == WIN_LAST);

  // Gate window counter; held at 0 while disabled so a fresh window starts on enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win <= '0;
    end else if (!enable || w_term) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= w_term;
    end
  end

  assign count_valid = r_count_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_hist;
      logic                   w_rise;
      logic [CNT_W-1:0]       r_ec;
      logic [CNT_W-1:0]       r_count;
      logic [CNT_W-1:0]       w_new;
      logic                   r_active;
      logic                   r_lost;
      logic                   w_low;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= '0;
          r_hist <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], clkout_in[gi]};
          r_hist <= r_sync[SYNC_STAGES-1];
        end
      end

      assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
      // An edge seen in the terminal cycle still belongs to the closing window.
      assign w_new  = (r_ec == CNT_MAX) ? CNT_MAX : r_ec + CNT_W'(w_rise);
      assign w_low  = ({1'b0, w_new} < MIN_C);

      always_ff @(posedge clk) begin
        if (reset || !enable || w_term) begin
          r_ec <= '0;
        end else if (w_rise && (r_ec != CNT_MAX)) begin
          r_ec <= r_ec + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_count  <= '0;
          r_active <= 1'b0;
        end else if (w_term) begin
          r_count  <= w_new;
          r_active <= ~w_low;
        end
      end

      // A loss detected at the terminal cycle beats a simultaneous clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_lost <= 1'b0;
        end else if (w_term && w_low) begin
          r_lost <= 1'b1;
        end else if (lost_clr[gi]) begin
          r_lost <= 1'b0;
        end
      end

      assign count_out[gi*CNT_W +: CNT_W] = r_count;
      assign clk_active[gi]               = r_active;
      assign lost_sticky[gi]              = r_lost;
    end
  endgenerate

endmodule

// File: tb/tb_xcvr_clkout_freq_monitor.sv
// Scoreboard bench for xcvr_clkout_freq_monitor: directed clkout patterns, expected
// window results queued by the stimulus and checked by a monitor on each count_valid.
module tb_xcvr_clkout_freq_monitor;

  localparam int DC = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  lost_clr;
  logic [3:0]  clkin0;
  logic [3:0]  clkin1;
  logic        ch2_run;
  logic        ch3_lvl;
  logic        fast = 1'b0;
  int          cyc = 0;

  logic [31:0] cnt0;
  logic        cv0;
  logic [3:0]  act0;
  logic [3:0]  lost0;
  logic [15:0] cnt1;
  logic        cv1;
  logic [3:0]  act1;
  logic [3:0]  lost1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    int         cnt[4];
    int         tol[4];
    logic [3:0] act;
    logic [3:0] lost;
  } exp_t;

  exp_t q[$];

  xcvr_clkout_freq_monitor #(
    .NUM_CH(4), .SYNC_STAGES(3), .GATE_CYCLES(100), .CNT_W(8), .MIN_EDGES(1)
  ) u0 (
    .clk(clk), .reset(reset), .enable(enable), .clkout_in(clkin0), .lost_clr(lost_clr),
    .count_out(cnt0), .count_valid(cv0), .clk_active(act0), .lost_sticky(lost0)
  );

  xcvr_clkout_freq_monitor #(
    .NUM_CH(4), .SYNC_STAGES(3), .GATE_CYCLES(100), .CNT_W(4), .MIN_EDGES(1)
  ) u1 (
    .clk(clk), .reset(reset), .enable(enable), .clkout_in(clkin1), .lost_clr(4'b0000),
    .count_out(cnt1), .count_valid(cv1), .clk_active(act1), .lost_sticky(lost1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clkout patterns change on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    fast      = ~fast;
    clkin0[0] = (cyc % 4) < 2;
    clkin0[1] = (cyc % 10) < 5;
    clkin0[2] = ch2_run && ((cyc % 5) < 2);
    clkin0[3] = ch3_lvl;
    clkin1    = {3'b000, fast};
  end

  function automatic void chk(input string nm, input int got, input int req, input int tol);
    n_chk++;
    if (got < req - tol || got > req + tol) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d (tol %0d)", nm, cyc, got, req, tol);
    end
  endfunction

  function automatic void push(input int c,
                               input int c0, input int t0, input int c1, input int t1,
                               input int c2, input int t2, input int c3, input int t3,
                               input logic [3:0] a, input logic [3:0] l);
    exp_t e;
    e.cyc = c;
    e.cnt[0] = c0; e.tol[0] = t0;
    e.cnt[1] = c1; e.tol[1] = t1;
    e.cnt[2] = c2; e.tol[2] = t2;
    e.cnt[3] = c3; e.tol[3] = t3;
    e.act  = a;
    e.lost = l;
    q.push_back(e);
  endfunction

  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expectation per count_valid pulse; also catches missing pulses.
  always @(negedge clk) begin
    exp_t e;
    if (cv0) begin
      if (q.size() == 0) begin
        chk("unexpected_count_valid", 1, 0, 0);
      end else begin
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc, 0);
        for (int i = 0; i < 4; i++)
          chk($sformatf("count_ch%0d", i), int'(cnt0[i*8 +: 8]), e.cnt[i], e.tol[i]);
        chk("clk_active", int'(act0), int'(e.act), 0);
        chk("lost_sticky", int'(lost0), int'(e.lost), 0);
        $display("window @%0d: counts %0d/%0d/%0d/%0d active %b lost %b", cyc,
                 cnt0[7:0], cnt0[15:8], cnt0[23:16], cnt0[31:24], act0, lost0);
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missing_count_valid", 0, 1, 0);
    end
    if (cv0 || cv1) begin
      chk("sat_valid_align", int'(cv1), int'(cv0), 0);
      if (cv1) chk("sat_count_ch0", int'(cnt1[3:0]), 15, 0);
    end
  end

  initial begin
    int l0, l1, l2;
    reset    = 1'b1;
    enable   = 1'b1;
    lost_clr = 4'b0000;
    ch2_run  = 1'b0;
    ch3_lvl  = 1'b1;

    goto(2);
    chk("rst_count_out", int'(cnt0), 0, 0);
    chk("rst_count_valid", int'(cv0), 0, 0);
    chk("rst_clk_active", int'(act0), 0, 0);
    chk("rst_lost_sticky", int'(lost0), 0, 0);

    goto(5);
    reset = 1'b0;
    l0 = 5;
    // First window after reset: sync chain refill costs up to one edge; stuck-high ch3 shows one edge.
    push(l0 + 100, 25, 1, 10, 1,  0,  0, 1, 0, 4'b1011, 4'b0100);
    push(l0 + 200, 25, 0, 10, 0,  0,  0, 0, 0, 4'b0011, 4'b1100);
    push(l0 + 300, 25, 0, 10, 0,  0, DC, 0, 0, 4'b0111, 4'b1000);
    push(l0 + 400, 25, 0, 10, 0, 20,  0, 0, 0, 4'b0111, 4'b1000);
    push(l0 + 500, 25, 0, 10, 0,  0, DC, 0, 0, 4'b0111, 4'b1000);
    push(l0 + 600, 25, 0, 10, 0,  0,  0, 0, 0, 4'b0011, 4'b1100);

    goto(l0 + 210);
    ch2_run = 1'b1;
    goto(l0 + 219);
    chk("lost_before_clr", int'(lost0), 4'b1100, 0);
    goto(l0 + 220);
    lost_clr = 4'b0100;
    goto(l0 + 221);
    lost_clr = 4'b0000;
    goto(l0 + 225);
    chk("lost2_cleared", int'(lost0[2]), 0, 0);

    goto(l0 + 410);
    ch2_run = 1'b0;
    // Clear held up to and including the terminal cycle of a dead ch2 window.
    goto(l0 + 590);
    lost_clr = 4'b0100;
    goto(l0 + 600);
    lost_clr = 4'b0000;
    goto(l0 + 605);
    chk("lost2_set_wins", int'(lost0[2]), 1, 0);

    goto(l0 + 660);
    enable = 1'b0;
    goto(l0 + 670);
    chk("hold_count_ch0", int'(cnt0[7:0]), 25, 0);
    chk("hold_count_ch1", int'(cnt0[15:8]), 10, 0);
    chk("hold_no_valid", int'(cv0), 0, 0);
    goto(l0 + 680);
    enable = 1'b1;
    l1 = l0 + 680;
    push(l1 + 100, 25, 0, 10, 0, 0, 0, 0, 0, 4'b0011, 4'b1100);

    goto(l1 + 150);
    reset = 1'b1;
    goto(l1 + 151);
    reset = 1'b0;
    l2 = l1 + 151;
    chk("midrst_count_out", int'(cnt0), 0, 0);
    chk("midrst_count_valid", int'(cv0), 0, 0);
    chk("midrst_clk_active", int'(act0), 0, 0);
    chk("midrst_lost_sticky", int'(lost0), 0, 0);
    push(l2 + 100, 25, 1, 10, 1, 0, 0, 1, 0, 4'b1011, 4'b0100);
    push(l2 + 200, 25, 0, 10, 0, 0, 0, 0, 0, 4'b0011, 4'b1100);

    goto(l2 + 210);
    chk("scoreboard_drained", q.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
